// File: rtl/instr_register_ctrl.sv
// -----------------------------------------------------------------------------
// instr_register_ctrl
//   Write/read controller for a circular instruction register. Two producers
//   are arbitrated round-robin onto the single write port. Entries are popped
//   in order through a valid/ready interface toward the consumer.
//
// Ports
//   clk, reset_n            clock (rising edge), synchronous active-low reset
//   req{0,1}_valid/opcode/operand_a/operand_b   producer requests
//   req{0,1}_ready          grant to that producer this cycle
//   rd_ready / rd_valid     consumer pop handshake at read_pointer
//   load_en, opcode, operand_a, operand_b, write_pointer   register write port
//   read_pointer            register read address
//   occupancy, full         accepted-but-not-popped count, occupancy == DEPTH
// -----------------------------------------------------------------------------
module instr_register_ctrl #(
    parameter int DEPTH  = 32,
    parameter int PTR_W  = 5,
    parameter int OPC_W  = 4,
    parameter int OPND_W = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req0_valid,
    input  logic [OPC_W-1:0]         req0_opcode,
    input  logic signed [OPND_W-1:0] req0_operand_a,
    input  logic signed [OPND_W-1:0] req0_operand_b,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [OPC_W-1:0]         req1_opcode,
    input  logic signed [OPND_W-1:0] req1_operand_a,
    input  logic signed [OPND_W-1:0] req1_operand_b,
    output logic                     req1_ready,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic                     load_en,
    output logic [OPC_W-1:0]         opcode,
    output logic signed [OPND_W-1:0] operand_a,
    output logic signed [OPND_W-1:0] operand_b,
    output logic [PTR_W-1:0]         write_pointer,
    output logic [PTR_W-1:0]         read_pointer,
    output logic [PTR_W:0]           occupancy,
    output logic                     full
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0] alloc_ptr;
    logic [PTR_W:0]   avail;
    logic             last_grant;   // 1: producer 1 was granted last
    logic             accept0;
    logic             accept1;
    logic             accept;
    logic             pop;

    assign full = (occupancy == CNT_FULL);

    // Readies come only from registered state plus the valids, and are
    // suppressed while reset is asserted so nothing looks accepted then.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (reset_n && !full) begin
            if (req0_valid && req1_valid) begin
                req0_ready = last_grant;
                req1_ready = !last_grant;
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    assign rd_valid = reset_n && (avail != '0);
    assign accept0  = req0_valid && req0_ready;
    assign accept1  = req1_valid && req1_ready;
    assign accept   = accept0 || accept1;
    assign pop      = rd_valid && rd_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            load_en       <= 1'b0;
            opcode        <= '0;
            operand_a     <= '0;
            operand_b     <= '0;
            write_pointer <= '0;
            read_pointer  <= '0;
            alloc_ptr     <= '0;
            occupancy     <= '0;
            avail         <= '0;
            last_grant    <= 1'b1;
        end else begin
            load_en <= accept;
            if (accept0) begin
                opcode        <= req0_opcode;
                operand_a     <= req0_operand_a;
                operand_b     <= req0_operand_b;
                write_pointer <= alloc_ptr;
                alloc_ptr     <= alloc_ptr + PTR_ONE;
                last_grant    <= 1'b0;
            end else if (accept1) begin
                opcode        <= req1_opcode;
                operand_a     <= req1_operand_a;
                operand_b     <= req1_operand_b;
                write_pointer <= alloc_ptr;
                alloc_ptr     <= alloc_ptr + PTR_ONE;
                last_grant    <= 1'b1;
            end

            if (accept && !pop) begin
                occupancy <= occupancy + CNT_ONE;
            end else if (!accept && pop) begin
                occupancy <= occupancy - CNT_ONE;
            end

            // The register commits at the edge that ends the load_en cycle,
            // so the pending pulse itself is the commit strobe.
            if (load_en && !pop) begin
                avail <= avail + CNT_ONE;
            end else if (!load_en && pop) begin
                avail <= avail - CNT_ONE;
            end

            if (pop) begin
                read_pointer <= read_pointer + PTR_ONE;
            end
        end
    end

endmodule

// File: doc/instr_register_ctrl.md
Name: instr_register_ctrl

Overview:
- Write/read controller for the 32-entry instruction register (instr_register).
- Arbitrates two instruction producers onto the single write port with round-robin priority.
- Drives load_en, opcode, operand_a, operand_b and write_pointer into the register.
- Sequences read_pointer so the register behaves as a circular FIFO, with a valid/ready pop interface toward the consumer.

Parameters:
- DEPTH, 32, number of register entries; power of two.
- PTR_W, 5, pointer width; log2(DEPTH).
- OPC_W, 4, opcode width (opcode_t).
- OPND_W, 32, operand width (signed operand_t).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req0_valid  in  1  producer 0 has an instruction.
- req0_opcode  in  OPC_W  producer 0 opcode.
- req0_operand_a  in  OPND_W  producer 0 operand A.
- req0_operand_b  in  OPND_W  producer 0 operand B.
- req0_ready  out  1  producer 0 accepted this cycle.
- req1_valid, req1_opcode, req1_operand_a, req1_operand_b, req1_ready: same as producer 0.
- rd_ready  in  1  consumer takes the entry at read_pointer.
- rd_valid  out  1  committed entry available at read_pointer.
- load_en  out  1  write strobe to the register.
- opcode  out  OPC_W  write data.
- operand_a  out  OPND_W  write data.
- operand_b  out  OPND_W  write data.
- write_pointer  out  PTR_W  write address.
- read_pointer  out  PTR_W  read address; instruction_word is read combinationally by the consumer.
- occupancy  out  PTR_W+1  accepted, not-yet-popped entries (0..DEPTH).
- full  out  1  occupancy == DEPTH.

Behaviour:
- Reset: the sampled reset_n=0 at a rising edge clears all state.
  - load_en=0, opcode=0 (ZERO), operand_a=0, operand_b=0.
  - write_pointer=0, read_pointer=0, occupancy=0, avail=0.
  - Internal alloc pointer=0; last_grant=1, so producer 0 wins first.
  - While reset_n=0: req0_ready, req1_ready and rd_valid are forced to 0.
- Arbitration (combinational from registered state):
  - Grant only if !full.
  - Only one valid: grant it.
  - Both valid: grant the requester other than last_grant.
  - reqN_ready = grant to N. At most one ready per cycle.
- Accept = reqN_valid && reqN_ready. At that edge:
  - load_en<=1, opcode/operands<=the winner's fields, write_pointer<=alloc pointer.
  - alloc pointer<=alloc+1, wrapping at DEPTH-1 to 0.
  - last_grant<=N, occupancy<=occupancy+1.
- No accept: load_en<=0. Data outputs hold their last value.
- load_en is a one-cycle pulse per accept; back-to-back accepts give consecutive pulses at consecutive addresses.
- Commit: the register writes at the edge ending the load_en cycle, and avail (committed, unpopped count) increments at that same edge.
- rd_valid = (avail != 0). Data is readable 2 cycles after accept.
- Pop = rd_valid && rd_ready. At that edge:
  - read_pointer<=read_pointer+1 (wraps).
  - occupancy and avail each decrement.
  - rd_ready while rd_valid=0 is ignored.
- Simultaneous accept and pop: occupancy unchanged. A load_en commit plus pop in the same edge leaves avail unchanged.
- Full: ready is computed from registered occupancy, so after the DEPTH-th accept both readies are 0 from the next cycle on.
  - A pop at edge E re-enables ready in the cycle after E.
  - The next accept writes the slot freed earlier (wrapped).
- Invariants: avail <= occupancy <= DEPTH, and occupancy-avail <= 1. No writes to unpopped slots.
- Reset mid-operation: a pending load_en is dropped (load_en=0 after the reset edge). All pointers and counts return to 0, and prior contents are treated as discarded.
- Producer fields must be stable only in the accept cycle; the controller captures them.

Test Plan:
- Reset: reset_n=0 for 3 cycles with req0_valid=1 and rd_ready=1 -> req0_ready=0, load_en=0, write_pointer=read_pointer=0, rd_valid=0, occupancy=0.
- Single write/read: req0 ADD, a=5, b=3, accepted at cycle t.
  - t+1: load_en=1, write_pointer=0, opcode=ADD, operand_a=5, operand_b=3.
  - t+2: rd_valid=1 at read_pointer=0.
  - Pop: read_pointer=1, rd_valid=0, occupancy=0.
- Contention: both producers valid for 4 cycles -> grants 0,1,0,1; write_pointer 0,1,2,3 on consecutive load_en pulses; occupancy=4.
- Full/wrap: 32 accepts with no pops -> full=1, both readies 0, 33rd request stalls. One pop -> ready next cycle; the stalled instruction writes at write_pointer=0.
- Simultaneous: at occupancy=31, accept and pop in the same cycle -> occupancy stays 31 and full stays 0.
- Reset mid-op: accept at t, reset_n=0 sampled at the end of t+1 -> load_en=0 in t+2, pointers=0, occupancy=0, avail=0, rd_valid=0.
